// File: rtl/ddr_rw_arbiter.sv
// Round-robin arbiter sharing one DDR4 MIG app interface between a read job and a write job.
// Each granted job issues single-beat commands at consecutive ADDR_STEP-spaced addresses.
module ddr_rw_arbiter #(
  parameter int ADDR_W    = 28,
  parameter int DATA_W    = 576,
  parameter int LEN_W     = 6,
  parameter int ADDR_STEP = 8
) (
  input  logic              c0_ddr4_ui_clk,
  input  logic              c0_ddr4_ui_clk_sync_rst,
  input  logic              c0_init_calib_complete,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_base,
  input  logic [LEN_W-1:0]  rd_len,
  output logic              rd_grant,
  output logic              rd_done,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_base,
  input  logic [LEN_W-1:0]  wr_len,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_data_pop,
  output logic              wr_grant,
  output logic              wr_done,
  output logic [ADDR_W-1:0] c0_ddr4_app_addr,
  output logic [2:0]        c0_ddr4_app_cmd,
  output logic              c0_ddr4_app_en,
  input  logic              c0_ddr4_app_rdy,
  output logic [DATA_W-1:0] c0_ddr4_app_wdf_data,
  output logic              c0_ddr4_app_wdf_wren,
  output logic              c0_ddr4_app_wdf_end,
  input  logic              c0_ddr4_app_wdf_rdy,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_cur_addr;
  logic [ADDR_W-1:0] r_addr_hold;
  logic [LEN_W-1:0]  r_remaining;
  logic              r_rd_grant;
  logic              r_wr_grant;
  logic              r_last_grant_wr;
  logic              w_pick_rd;
  logic              w_pick_wr;
  logic              w_wr_go;
  logic              w_accept;
  logic              w_last;

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_pick_rd = 1'b0;
    w_pick_wr = 1'b0;
    if (r_state == S_IDLE && c0_init_calib_complete) begin
      if (rd_req && wr_req) begin
        w_pick_rd = r_last_grant_wr;
        w_pick_wr = !r_last_grant_wr;
      end else begin
        w_pick_rd = rd_req;
        w_pick_wr = wr_req;
      end
    end
  end

  // Write command and data beat always go together, so one qualifier covers both channels.
  assign w_wr_go  = c0_init_calib_complete & c0_ddr4_app_rdy & c0_ddr4_app_wdf_rdy;
  assign w_accept = ((r_state == S_RD) & c0_init_calib_complete & c0_ddr4_app_rdy) |
                    ((r_state == S_WR) & w_wr_go);
  assign w_last   = w_accept && (r_remaining == LEN_W'(1));

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge c0_ddr4_ui_clk) begin
    if (c0_ddr4_ui_clk_sync_rst) r_state <= S_IDLE;
    else                         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_pick_rd)      w_next = (rd_len == '0) ? S_DONE : S_RD;
        else if (w_pick_wr) w_next = (wr_len == '0) ? S_DONE : S_WR;
      end
      S_RD, S_WR: if (w_last) w_next = S_DONE;
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge c0_ddr4_ui_clk) begin
    if (c0_ddr4_ui_clk_sync_rst) begin
      r_cur_addr      <= '0;
      r_addr_hold     <= '0;
      r_remaining     <= '0;
      r_rd_grant      <= 1'b0;
      r_wr_grant      <= 1'b0;
      r_last_grant_wr <= 1'b1;
    end else begin
      r_addr_hold <= c0_ddr4_app_addr;
      if (w_pick_rd) begin
        r_cur_addr  <= rd_base;
        r_remaining <= rd_len;
        r_rd_grant  <= 1'b1;
      end else if (w_pick_wr) begin
        r_cur_addr  <= wr_base;
        r_remaining <= wr_len;
        r_wr_grant  <= 1'b1;
      end else if (w_accept) begin
        r_cur_addr  <= r_cur_addr + ADDR_W'(ADDR_STEP);
        r_remaining <= r_remaining - LEN_W'(1);
      end
      if (r_state == S_DONE) begin
        r_rd_grant      <= 1'b0;
        r_wr_grant      <= 1'b0;
        r_last_grant_wr <= r_wr_grant;
      end
    end
  end

  // Outside RD/WR the address output replays its previous value.
  always_comb begin
    c0_ddr4_app_addr     = r_addr_hold;
    c0_ddr4_app_cmd      = 3'd0;
    c0_ddr4_app_en       = 1'b0;
    c0_ddr4_app_wdf_data = '0;
    c0_ddr4_app_wdf_wren = 1'b0;
    c0_ddr4_app_wdf_end  = 1'b0;
    wr_data_pop          = 1'b0;
    unique case (r_state)
      S_RD: begin
        c0_ddr4_app_addr = r_cur_addr;
        c0_ddr4_app_cmd  = 3'd1;
        c0_ddr4_app_en   = c0_init_calib_complete;
      end
      S_WR: begin
        c0_ddr4_app_addr     = r_cur_addr;
        c0_ddr4_app_en       = w_wr_go;
        c0_ddr4_app_wdf_data = wr_data;
        c0_ddr4_app_wdf_wren = w_wr_go;
        c0_ddr4_app_wdf_end  = w_wr_go;
        wr_data_pop          = w_wr_go;
      end
      default: ;
    endcase
  end

  assign rd_grant = r_rd_grant;
  assign wr_grant = r_wr_grant;
  assign rd_done  = (r_state == S_DONE) & r_rd_grant;
  assign wr_done  = (r_state == S_DONE) & r_wr_grant;
  assign busy     = (r_state != S_IDLE);

endmodule

// File: doc/ddr_rw_arbiter.md
DDR_RW_ARBITER -- requirements
Module: ddr_rw_arbiter

Interface
REQ-001 Parameters (name, default, meaning): ADDR_W, 28, DDR4 app address width; DATA_W, 576, app data width; LEN_W, 6, burst-count width; ADDR_STEP, 8, address increment per command.
REQ-002 c0_ddr4_ui_clk  in  1  sole clock; all logic on rising edge.
REQ-003 c0_ddr4_ui_clk_sync_rst  in  1  reset, synchronous, active-high.
REQ-004 c0_init_calib_complete  in  1  DDR calibration done; no command is issued while low.
REQ-005 rd_req  in  1, rd_base  in  ADDR_W, rd_len  in  LEN_W  read job: start address and number of commands.
REQ-006 rd_grant  out  1  read job owns the DDR; rd_done  out  1  one-cycle pulse when the read job completes.
REQ-007 wr_req  in  1, wr_base  in  ADDR_W, wr_len  in  LEN_W  write job: start address and number of commands.
REQ-008 wr_data  in  DATA_W  current write beat from the write BRAM; wr_data_pop  out  1  beat consumed; advance BRAM address.
REQ-009 wr_grant  out  1, wr_done  out  1  write-job equivalents of rd_grant and rd_done.
REQ-010 c0_ddr4_app_addr  out  ADDR_W, c0_ddr4_app_cmd  out  3, c0_ddr4_app_en  out  1, c0_ddr4_app_rdy  in  1  command channel.
REQ-011 c0_ddr4_app_wdf_data  out  DATA_W, c0_ddr4_app_wdf_wren  out  1, c0_ddr4_app_wdf_end  out  1, c0_ddr4_app_wdf_rdy  in  1  write-data channel.
REQ-012 busy  out  1  high in every state other than IDLE.

Function
REQ-013 FSM states: IDLE, RD, WR, DONE.
REQ-014 IDLE: a job may be granted only when c0_init_calib_complete=1. If exactly one request is high, that job is granted. If both are high, the job not granted most recently is granted (round-robin on a last_grant register).
REQ-015 On grant: latch the base address into cur_addr and the length into remaining; set the grant output. Next state is RD or WR, or DONE if the latched length is 0.
REQ-016 The grant output stays high from the grant cycle through the DONE cycle inclusive. The requester must hold req high until it sees the done pulse. Base and len are sampled only at grant.
REQ-017 RD: app_cmd=3'd1, app_addr=cur_addr, app_en = c0_init_calib_complete.
REQ-018 RD: a command is accepted in a cycle where app_en=1 and app_rdy=1. On acceptance, cur_addr+=ADDR_STEP and remaining-=1. When the last command is accepted, go to DONE.
REQ-019 WR: app_cmd=3'd0, app_addr=cur_addr, app_wdf_data=wr_data.
REQ-020 WR: app_en, app_wdf_wren, app_wdf_end and wr_data_pop are all equal to (c0_init_calib_complete & app_rdy & app_wdf_rdy). Command and data are therefore always accepted in the same cycle.
REQ-021 WR: each accepted beat advances cur_addr and remaining as in REQ-018. The last accepted beat moves the FSM to DONE.
REQ-022 DONE: pulse rd_done or wr_done for exactly one cycle, update last_grant, return to IDLE. app_en and wdf_wren are 0. A new grant is possible in the cycle after DONE at the earliest.
REQ-023 Address arithmetic is modulo 2^ADDR_W; wrap-around at the top of the address space is silent.
REQ-024 If calibration drops mid-job: stall with no enables and no counter changes, then resume from the same cur_addr and remaining once it returns.
REQ-025 Outside RD and WR: app_en, app_wdf_wren, app_wdf_end and wr_data_pop are 0; app_cmd=3'd0; app_addr holds its value.
REQ-026 The maximum job length is 2^LEN_W-1 commands.

Reset
REQ-027 Reset: state=IDLE, all outputs 0, cur_addr=0, remaining=0, last_grant=write (so the first contended grant goes to read).
REQ-028 Reset asserted mid-job aborts the job: no done pulse is generated, and there is no further app_en or wdf_wren from the following cycle on.

Verification
REQ-029 rd_req=1, rd_base=0x100, rd_len=3, app_rdy=1 -> app_en for 3 cycles at addresses 0x100, 0x108, 0x110 with cmd=1, then one rd_done pulse.
REQ-030 rd_req and wr_req both high after reset -> read granted first, write granted immediately after rd_done; with both held again, the next grant goes to read.
REQ-031 Write job with wr_len=2 and app_wdf_rdy low for 4 cycles -> no wren/en/pop until ready; exactly 2 pops, 2 wren, then wr_done.
REQ-032 rd_base=0xFFFFFF8, rd_len=2 -> addresses issued are 0xFFFFFF8 then 0x0000000.
REQ-033 rd_len=0 -> grant, then rd_done pulse with no app_en; calib low at request -> no grant until calib=1.
REQ-034 Reset pulsed after one beat of a 4-beat write -> outputs 0, no wr_done; a fresh job afterwards starts from its new base.
